core_ncache_router: RTL and testbench

- Sits between the core data-memory port and two memory paths: the data cache and the non-cacheable (uncached/IO) path.
- Consumes the ncache_base/ncache_mask window published by the CSR block and classifies each core request against it.
- Forwards each request to exactly one path and returns that path's response to the core.
- Single outstanding transaction, strictly in order.

---
 rtl/core_ncr_pkg.sv | 13 +
 rtl/core_ncache_match.sv | 14 +
 rtl/core_ncache_router.sv | 209 ++++++++++++++++++++
 tb/tb_core_ncache_router.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ncr_pkg.sv
// Shared definitions for the core non-cacheable router: FSM state encoding
// and the default timeout counter width.
package core_ncr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ncr_state_e;

    localparam int NCR_TIMEOUT_W = 8;

endpackage

// File: rtl/core_ncache_match.sv
// Combinational non-cacheable window compare: hit when every masked address
// bit equals the corresponding base bit. Shared with the fetch path.
module core_ncache_match #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] mask_i,
    output logic          hit_o
);

    assign hit_o = (((addr_i ^ base_i) & mask_i) == '0);

endmodule

// File: rtl/core_ncache_router.sv
// Routes single outstanding core data requests to the cache or non-cacheable
// path. Optional NCR_TIMEOUT_EN adds a response timeout with late-response drop.
module core_ncache_router
    import core_ncr_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT_W = NCR_TIMEOUT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ncache_base,
    input  logic [AW-1:0]   ncache_mask,
    input  logic            core_req_val,
    output logic            core_req_ack,
    input  logic [AW-1:0]   core_req_addr,
    input  logic            core_req_we,
    input  logic [DW/8-1:0] core_req_be,
    input  logic [DW-1:0]   core_req_wdata,
    output logic            core_rsp_val,
    output logic [DW-1:0]   core_rsp_data,
    output logic            core_rsp_err,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_we,
    output logic [DW/8-1:0] mem_req_be,
    output logic [DW-1:0]   mem_req_wdata,
    output logic            c_req_val,
    input  logic            c_req_ack,
    input  logic            c_rsp_val,
    input  logic [DW-1:0]   c_rsp_data,
    output logic            nc_req_val,
    input  logic            nc_req_ack,
    input  logic            nc_rsp_val,
    input  logic [DW-1:0]   nc_rsp_data
);

    ncr_state_e      state_q, state_d;
    logic            sel_nc_q, sel_nc_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            c_req_val_q, c_req_val_d;
    logic            nc_req_val_q, nc_req_val_d;
    logic            rsp_val_q, rsp_val_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic            hit;
    logic            cur_req_val, sel_ack, sel_rsp;
    logic [DW-1:0]   sel_data;
    logic            to_fire;
    logic            drop_c_q, drop_nc_q, drop_c_d, drop_nc_d;

    core_ncache_match #(.AW(AW)) u_match (
        .addr_i (core_req_addr),
        .base_i (ncache_base),
        .mask_i (ncache_mask),
        .hit_o  (hit)
    );

    assign core_req_ack = (state_q == IDLE);
    assign cur_req_val  = sel_nc_q ? nc_req_val_q : c_req_val_q;
    assign sel_ack      = sel_nc_q ? nc_req_ack : c_req_ack;
    assign sel_data     = sel_nc_q ? nc_rsp_data : c_rsp_data;
    // A response owed to a timed-out request must never complete a newer one.
    assign sel_rsp      = sel_nc_q ? (nc_rsp_val && !drop_nc_q) : (c_rsp_val && !drop_c_q);

`ifdef NCR_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 rsp_err_q;

    assign to_fire = (state_q != IDLE) && (cnt_q == '1) && !(state_q == WAIT && sel_rsp);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (core_req_val) cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        drop_c_d  = drop_c_q;
        drop_nc_d = drop_nc_q;
        if (drop_c_q && c_rsp_val)   drop_c_d  = 1'b0;
        if (drop_nc_q && nc_rsp_val) drop_nc_d = 1'b0;
        if (to_fire) begin
            if (sel_nc_q) drop_nc_d = 1'b1;
            else          drop_c_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            drop_c_q  <= 1'b0;
            drop_nc_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            drop_c_q  <= drop_c_d;
            drop_nc_q <= drop_nc_d;
            rsp_err_q <= to_fire;
        end
    end

    assign core_rsp_err = rsp_err_q;
`else
    logic [TIMEOUT_W-1:0] unused_timeout_w;

    assign unused_timeout_w = '0;
    assign to_fire          = 1'b0;
    assign drop_c_q         = 1'b0;
    assign drop_nc_q        = 1'b0;
    assign drop_c_d         = 1'b0;
    assign drop_nc_d        = 1'b0;
    assign core_rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sel_nc_d     = sel_nc_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        c_req_val_d  = c_req_val_q;
        nc_req_val_d = nc_req_val_q;
        rsp_val_d    = 1'b0;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (core_req_val) begin
                    state_d      = REQ;
                    sel_nc_d     = hit;
                    addr_d       = core_req_addr;
                    we_d         = core_req_we;
                    be_d         = core_req_be;
                    wdata_d      = core_req_wdata;
                    c_req_val_d  = !hit && !drop_c_d;
                    nc_req_val_d = hit && !drop_nc_d;
                end
            end
            REQ: begin
                if (cur_req_val && sel_ack) begin
                    state_d      = WAIT;
                    c_req_val_d  = 1'b0;
                    nc_req_val_d = 1'b0;
                end else begin
                    // Held off while the selected path still owes a dropped response.
                    c_req_val_d  = !sel_nc_q && !drop_c_d;
                    nc_req_val_d = sel_nc_q && !drop_nc_d;
                end
            end
            WAIT: begin
                if (sel_rsp) begin
                    state_d    = IDLE;
                    rsp_val_d  = 1'b1;
                    rsp_data_d = sel_data;
                end
            end
            default: state_d = IDLE;
        endcase
        if (to_fire) begin
            state_d      = IDLE;
            c_req_val_d  = 1'b0;
            nc_req_val_d = 1'b0;
            rsp_val_d    = 1'b1;
            rsp_data_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_nc_q     <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            c_req_val_q  <= 1'b0;
            nc_req_val_q <= 1'b0;
            rsp_val_q    <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_nc_q     <= sel_nc_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            c_req_val_q  <= c_req_val_d;
            nc_req_val_q <= nc_req_val_d;
            rsp_val_q    <= rsp_val_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_be    = be_q;
    assign mem_req_wdata = wdata_q;
    assign c_req_val     = c_req_val_q;
    assign nc_req_val    = nc_req_val_q;
    assign core_rsp_val  = rsp_val_q;
    assign core_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_core_ncache_router.sv
// Self-checking bench for core_ncache_router: directed and randomized
// transactions against a bitwise window model and per-cycle protocol checks.
module tb_core_ncache_router;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef NCR_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ncache_base = '0, ncache_mask = '0;
    logic          core_req_val = 1'b0, core_req_we = 1'b0;
    logic          core_req_ack;
    logic [AW-1:0] core_req_addr = '0;
    logic [3:0]    core_req_be = '0;
    logic [DW-1:0] core_req_wdata = '0;
    logic          core_rsp_val, core_rsp_err;
    logic [DW-1:0] core_rsp_data;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_we;
    logic [3:0]    mem_req_be;
    logic [DW-1:0] mem_req_wdata;
    logic          c_req_val, nc_req_val;
    logic          c_req_ack = 1'b0, c_rsp_val = 1'b0, nc_req_ack = 1'b0, nc_rsp_val = 1'b0;
    logic [DW-1:0] c_rsp_data = '0, nc_rsp_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_ncache_router #(.AW(AW), .DW(DW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ncache_base(ncache_base), .ncache_mask(ncache_mask),
        .core_req_val(core_req_val), .core_req_ack(core_req_ack),
        .core_req_addr(core_req_addr), .core_req_we(core_req_we),
        .core_req_be(core_req_be), .core_req_wdata(core_req_wdata),
        .core_rsp_val(core_rsp_val), .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .c_req_val(c_req_val), .c_req_ack(c_req_ack),
        .c_rsp_val(c_rsp_val), .c_rsp_data(c_rsp_data),
        .nc_req_val(nc_req_val), .nc_req_ack(nc_req_ack),
        .nc_rsp_val(nc_rsp_val), .nc_rsp_data(nc_rsp_data)
    );

    // Window rule stated per bit: every masked bit of addr must equal base.
    function automatic bit model_nc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
        for (int i = 0; i < 32; i++)
            if (m[i] && (a[i] != b[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_paths();
        c_req_ack = 1'b0; nc_req_ack = 1'b0;
        c_rsp_val = 1'b0; nc_rsp_val = 1'b0;
    endtask

    // One full transaction; pre = already accepted by a previous b2b call,
    // b2b = present a new read of na while the response pulse is out.
    task automatic run_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] base, input logic [31:0] mask,
                           input int ack_dly, input int rsp_dly, input logic [31:0] rd,
                           input bit chg, input bit pre, input bit b2b, input logic [31:0] na);
        bit nc;
        nc = model_nc(a, base, mask);
        if (!pre) begin
            ncache_base = base; ncache_mask = mask;
            core_req_addr = a; core_req_we = we; core_req_be = be; core_req_wdata = wd;
            core_req_val = 1'b1;
            checks++;
            if (core_req_ack !== 1'b1) begin
                failures++; $display("FAIL accept_ack got=%b exp=1", core_req_ack);
            end
            tick();
        end
        core_req_val = 1'b0;
        core_req_addr = $urandom; core_req_wdata = $urandom; core_req_we = ~we; core_req_be = ~be;
        if (chg) ncache_base = base ^ 32'hFFFF_FFFF;
        if (nc) begin c_req_ack = 1'b1; c_rsp_val = 1'b1; c_rsp_data = $urandom; nc_rsp_val = 1'b1; nc_rsp_data = $urandom; end
        else    begin nc_req_ack = 1'b1; nc_rsp_val = 1'b1; nc_rsp_data = $urandom; c_rsp_val = 1'b1; c_rsp_data = $urandom; end
        for (int i = 0; i <= ack_dly; i++) begin
            if (i == ack_dly) begin
                if (nc) begin nc_req_ack = 1'b1; nc_rsp_val = 1'b0; end
                else    begin c_req_ack = 1'b1; c_rsp_val = 1'b0; end
            end
            checks++;
            if ({c_req_val, nc_req_val} !== {~nc, nc}) begin
                failures++; $display("FAIL route addr=%h got c=%b nc=%b exp nc=%b", a, c_req_val, nc_req_val, nc);
            end
            checks++;
            if ({mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata} !== {a, we, be, wd}) begin
                failures++; $display("FAIL mem_req got=%h/%b/%b/%h exp=%h/%b/%b/%h",
                    mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, a, we, be, wd);
            end
            checks++;
            if (core_rsp_val !== 1'b0) begin
                failures++; $display("FAIL early_rsp_req got=%b exp=0", core_rsp_val);
            end
            tick();
        end
        c_req_ack = 1'b0; nc_req_ack = 1'b0;
        checks++;
        if ({c_req_val, nc_req_val} !== 2'b00) begin
            failures++; $display("FAIL req_drop got=%b%b exp=00", c_req_val, nc_req_val);
        end
        for (int i = 0; i < rsp_dly; i++) begin
            checks++;
            if (core_rsp_val !== 1'b0) begin
                failures++; $display("FAIL early_rsp_wait got=%b exp=0", core_rsp_val);
            end
            tick();
        end
        if (nc) begin nc_rsp_val = 1'b1; nc_rsp_data = rd; end
        else    begin c_rsp_val = 1'b1; c_rsp_data = rd; end
        if (b2b) begin
            core_req_val = 1'b1; core_req_addr = na; core_req_we = 1'b0;
            core_req_be = 4'hF; core_req_wdata = '0;
        end
        tick();
        quiet_paths();
        checks++;
        if ({core_rsp_val, core_rsp_err, core_rsp_data} !== {1'b1, 1'b0, rd}) begin
            failures++; $display("FAIL rsp got val=%b err=%b data=%h exp 1/0/%h",
                core_rsp_val, core_rsp_err, core_rsp_data, rd);
        end
        checks++;
        if (core_req_ack !== 1'b1) begin
            failures++; $display("FAIL ack_in_rsp_cycle got=%b exp=1", core_req_ack);
        end
        tick();
        checks++;
        if (core_rsp_val !== 1'b0) begin
            failures++; $display("FAIL rsp_pulse got=%b exp=0", core_rsp_val);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({c_req_val, nc_req_val, core_rsp_val, core_rsp_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctl got=%b%b%b%b exp=0000", c_req_val, nc_req_val, core_rsp_val, core_rsp_err);
        end
        checks++;
        if ({core_rsp_data, mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata} !== '0) begin
            failures++; $display("FAIL reset_data got rsp=%h addr=%h", core_rsp_data, mem_req_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (core_req_ack !== 1'b1) begin
            failures++; $display("FAIL reset_ack got=%b exp=1", core_req_ack);
        end
    endtask

    task automatic test_nc_read();
        run_txn(32'h8000_0010, 1'b0, 4'hF, 32'h0, 32'h8000_0000, 32'hF000_0000,
                0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_cache_write();
        run_txn(32'h1000_0004, 1'b1, 4'b0011, 32'hCAFE_1234, 32'h8000_0000, 32'hF000_0000,
                4, 1, 32'h5A5A_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_window_bounds();
        for (int i = 0; i < 4; i++)
            run_txn($urandom, 1'b0, 4'hF, 32'h0, $urandom, 32'h0, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
        run_txn(32'h4, 1'b0, 4'hF, 32'h0, 32'h4, 32'hFFFF_FFFF, 0, 0, 32'h1111_0004, 1'b0, 1'b0, 1'b0, 32'h0);
        run_txn(32'h8, 1'b0, 4'hF, 32'h0, 32'h4, 32'hFFFF_FFFF, 0, 0, 32'h2222_0008, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        // Base flips right after accept; the in-flight read keeps its path and
        // the follow-up read is classified against the flipped base.
        run_txn(32'h8000_0020, 1'b0, 4'hF, 32'h0, 32'h8000_0000, 32'hF000_0000,
                1, 2, 32'hABCD_0001, 1'b1, 1'b0, 1'b1, 32'h7000_0000);
        run_txn(32'h7000_0000, 1'b0, 4'hF, 32'h0, 32'h7FFF_FFFF, 32'hF000_0000,
                0, 1, 32'hABCD_0002, 1'b0, 1'b1, 1'b0, 32'h0);
        run_txn(32'h1000_0000, 1'b0, 4'hF, 32'h0, 32'h8000_0000, 32'hF000_0000,
                0, 0, 32'hABCD_0003, 1'b1, 1'b0, 1'b1, 32'h9000_0000);
        run_txn(32'h9000_0000, 1'b0, 4'hF, 32'h0, 32'h7FFF_FFFF, 32'hF000_0000,
                2, 0, 32'hABCD_0004, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a, b, m;
        for (int n = 0; n < 25; n++) begin
            b = $urandom;
            m = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            a = ($urandom_range(0, 1) == 1) ? (b ^ ($urandom & ~m)) : $urandom;
            run_txn(a, 1'($urandom), 4'($urandom), $urandom, b, m,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        ncache_base = 32'h8000_0000; ncache_mask = 32'hF000_0000;
        core_req_addr = 32'h8000_0044; core_req_we = 1'b0; core_req_be = 4'hF; core_req_val = 1'b1;
        tick();
        core_req_val = 1'b0;
        checks++;
        if (nc_req_val !== 1'b1) begin
            failures++; $display("FAIL mid_req_pre got=%b exp=1", nc_req_val);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c_req_val, nc_req_val, mem_req_addr} !== '0) begin
            failures++; $display("FAIL async_reset got c=%b nc=%b addr=%h exp 0", c_req_val, nc_req_val, mem_req_addr);
        end
        nc_req_ack = 1'b1; nc_rsp_val = 1'b1; c_req_ack = 1'b1; c_rsp_val = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({core_rsp_val, c_req_val, nc_req_val} !== 3'b000) begin
                failures++; $display("FAIL post_reset got rsp=%b c=%b nc=%b exp 000", core_rsp_val, c_req_val, nc_req_val);
            end
        end
        quiet_paths();
        tick();
    endtask

`ifdef NCR_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        ncache_base = 32'h8000_0000; ncache_mask = 32'hF000_0000;
        core_req_addr = 32'h8000_0100; core_req_we = 1'b0; core_req_be = 4'hF; core_req_val = 1'b1;
        tick();
        core_req_val = 1'b0;
        nc_req_ack = 1'b1;
        tick();
        nc_req_ack = 1'b0;
        cyc = 2;
        while (core_rsp_val !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != (2 ** TW) + 1) begin
            failures++; $display("FAIL timeout_latency got=%0d exp=%0d", cyc, (2 ** TW) + 1);
        end
        checks++;
        if ({core_rsp_err, core_rsp_data} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL timeout_rsp got err=%b data=%h exp 1/0", core_rsp_err, core_rsp_data);
        end
        tick();
        core_req_addr = 32'h8000_0200; core_req_val = 1'b1;
        tick();
        core_req_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nc_req_val !== 1'b0) begin
                failures++; $display("FAIL drop_hold got=%b exp=0", nc_req_val);
            end
            tick();
        end
        nc_rsp_val = 1'b1; nc_rsp_data = 32'hBAD0_BAD0;
        tick();
        nc_rsp_val = 1'b0;
        checks++;
        if ({nc_req_val, core_rsp_val} !== 2'b10) begin
            failures++; $display("FAIL late_swallow got nc=%b rsp=%b exp 1/0", nc_req_val, core_rsp_val);
        end
        nc_req_ack = 1'b1;
        tick();
        nc_req_ack = 1'b0;
        nc_rsp_val = 1'b1; nc_rsp_data = 32'h1234_5678;
        tick();
        nc_rsp_val = 1'b0;
        checks++;
        if ({core_rsp_val, core_rsp_err, core_rsp_data} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            failures++; $display("FAIL after_timeout got val=%b err=%b data=%h", core_rsp_val, core_rsp_err, core_rsp_data);
        end
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nc_read();
        test_cache_write();
        test_window_bounds();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef NCR_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
